acc_sequencer: RTL and testbench

Fetch/decode/execute control unit for the 16-bit accumulator machine. Sits directly upstream of the single-port RAM and is its only master: drives address, read and write, consumes the registered read data. Holds PC, IR and the accumulator (AC) and performs load/store/add/sub/mul/div internally.

---
 rtl/acc_sequencer.sv | 178 +++++++++++++++++
 tb/tb_acc_sequencer.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/acc_sequencer.sv
// acc_sequencer: fetch/decode/execute control unit for the 16-bit accumulator
// machine. It is the only master of a single-port RAM with a one-cycle
// registered read. It holds PC, IR and AC and runs LOAD/STORE/ADD/SUB/MUL/DIV
// internally.
module acc_sequencer #(
  parameter logic [10:0] RESET_PC = 11'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] mem_data_out,
  output logic [15:0] mem_data_in,
  output logic        mem_write,
  output logic        mem_read,
  output logic [10:0] mem_address,
  output logic [15:0] acc,
  output logic [10:0] pc,
  output logic        halted,
  output logic        err,
  output logic        div_zero
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_FLATCH,
    S_DECODE,
    S_ORD,
    S_OLATCH,
    S_STORE,
    S_HALT
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [15:0] ir;
  logic [3:0]  op;
  logic        mem_operand;
  logic [10:0] field;
  logic [15:0] imm;
  logic [15:0] opnd;
  logic        is_alu;
  logic        is_store;
  logic        is_halt;
  logic        is_illegal;
  logic        exec;
  logic [15:0] alu_result;
  logic        alu_div_zero;
  logic signed [15:0] quotient;

  assign op          = ir[15:12];
  assign mem_operand = ir[11];
  assign field       = ir[10:0];
  assign imm         = {{5{ir[10]}}, ir[10:0]};
  assign opnd        = (state == S_OLATCH) ? mem_data_out : imm;

  // Store data always mirrors AC, held at zero while reset is asserted.
  assign mem_data_in = reset ? 16'h0000 : acc;
  assign halted      = (state == S_HALT);

  // Classify the latched instruction; STORE without a memory operand is illegal.
  always_comb begin
    is_alu     = 1'b0;
    is_store   = 1'b0;
    is_halt    = 1'b0;
    is_illegal = 1'b0;
    case (op)
      4'd0:                     is_halt = 1'b1;
      4'd1, 4'd3, 4'd4, 4'd5, 4'd6: is_alu = 1'b1;
      4'd2: begin
        if (mem_operand) is_store = 1'b1;
        else             is_illegal = 1'b1;
      end
      default:                  is_illegal = 1'b1;
    endcase
  end

  // ALU: 16-bit wrapping arithmetic. Divide by -1 is done as negation so that
  // 8000/-1 wraps to 8000 without relying on signed-overflow behaviour.
  always_comb begin
    alu_result   = acc;
    alu_div_zero = 1'b0;
    quotient     = '0;
    case (op)
      4'd1: alu_result = opnd;
      4'd3: alu_result = acc + opnd;
      4'd4: alu_result = acc - opnd;
      4'd5: alu_result = acc * opnd;
      4'd6: begin
        if (opnd == 16'h0000) begin
          alu_div_zero = 1'b1;
        end else if (opnd == 16'hFFFF) begin
          alu_result = 16'h0000 - acc;
        end else begin
          quotient   = $signed(acc) / $signed(opnd);
          alu_result = quotient;
        end
      end
      default: alu_result = acc;
    endcase
  end

  // Next-state and Moore memory strobes; reset forces the bus idle.
  always_comb begin
    state_next  = state;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_address = 11'd0;
    exec        = 1'b0;
    case (state)
      S_FETCH: begin
        mem_read    = 1'b1;
        mem_address = pc;
        state_next  = S_FLATCH;
      end
      S_FLATCH: state_next = S_DECODE;
      S_DECODE: begin
        if (is_halt || is_illegal) begin
          state_next = S_HALT;
        end else if (is_store) begin
          state_next = S_STORE;
        end else if (is_alu && mem_operand) begin
          state_next = S_ORD;
        end else begin
          exec       = 1'b1;
          state_next = S_FETCH;
        end
      end
      S_ORD: begin
        mem_read    = 1'b1;
        mem_address = field;
        state_next  = S_OLATCH;
      end
      S_OLATCH: begin
        exec       = 1'b1;
        state_next = S_FETCH;
      end
      S_STORE: begin
        mem_write   = 1'b1;
        mem_address = field;
        state_next  = S_FETCH;
      end
      S_HALT:  state_next = S_HALT;
      default: state_next = S_FETCH;
    endcase
    if (reset) begin
      mem_read    = 1'b0;
      mem_write   = 1'b0;
      mem_address = 11'd0;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= S_FETCH;
    else       state <= state_next;
  end

  // Datapath registers: instruction latch, PC increment, execute and sticky flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc       <= RESET_PC;
      ir       <= 16'h0000;
      acc      <= 16'h0000;
      err      <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      if (state == S_FLATCH) begin
        ir <= mem_data_out;
        pc <= pc + 11'd1;
      end
      if (exec) begin
        acc <= alu_result;
        if (alu_div_zero) div_zero <= 1'b1;
      end
      if ((state == S_DECODE) && is_illegal) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_acc_sequencer.sv
// Testbench for acc_sequencer: a behavioural RAM with one-cycle registered read,
// two DUT instances (default and wrapped reset PC) multiplexed onto that RAM, and
// a scoreboard checking every store strobe and the machine state on halt.
module tb_acc_sequencer;

  typedef struct {
    logic [10:0] addr;
    logic [15:0] data;
  } store_t;

  typedef struct {
    logic [15:0] acc;
    logic [10:0] pc;
    logic        err;
    logic        dz;
    int          cycles;
  } halt_t;

  logic clk = 1'b0;
  logic reset0 = 1'b1;
  logic reset1 = 1'b1;
  logic sel = 1'b0;
  logic [15:0] rdata;

  logic [15:0] d0_din, d1_din, d0_acc, d1_acc;
  logic        d0_write, d1_write, d0_read, d1_read;
  logic [10:0] d0_addr, d1_addr, d0_pc, d1_pc;
  logic        d0_halted, d1_halted, d0_err, d1_err, d0_dz, d1_dz;

  logic [15:0] m_din, m_acc;
  logic        m_write, m_read, m_halted, m_err, m_dz, m_reset;
  logic [10:0] m_addr, m_pc;

  logic [15:0] ram [0:2047];
  logic        ram_clear = 1'b0;
  logic        ram_load = 1'b0;
  logic [10:0] ram_load_addr = '0;
  logic [15:0] ram_load_data = '0;

  logic [10:0] prog_a [$];
  logic [15:0] prog_d [$];
  store_t      store_q [$];
  halt_t       halt_q [$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  acc_sequencer dut0 (
    .clk(clk), .reset(reset0), .mem_data_out(rdata), .mem_data_in(d0_din),
    .mem_write(d0_write), .mem_read(d0_read), .mem_address(d0_addr),
    .acc(d0_acc), .pc(d0_pc), .halted(d0_halted), .err(d0_err), .div_zero(d0_dz)
  );

  acc_sequencer #(.RESET_PC(11'h7FF)) dut1 (
    .clk(clk), .reset(reset1), .mem_data_out(rdata), .mem_data_in(d1_din),
    .mem_write(d1_write), .mem_read(d1_read), .mem_address(d1_addr),
    .acc(d1_acc), .pc(d1_pc), .halted(d1_halted), .err(d1_err), .div_zero(d1_dz)
  );

  // The selected instance owns the RAM; the other one is held in reset.
  assign m_din    = sel ? d1_din    : d0_din;
  assign m_write  = sel ? d1_write  : d0_write;
  assign m_read   = sel ? d1_read   : d0_read;
  assign m_addr   = sel ? d1_addr   : d0_addr;
  assign m_acc    = sel ? d1_acc    : d0_acc;
  assign m_pc     = sel ? d1_pc     : d0_pc;
  assign m_halted = sel ? d1_halted : d0_halted;
  assign m_err    = sel ? d1_err    : d0_err;
  assign m_dz     = sel ? d1_dz     : d0_dz;
  assign m_reset  = sel ? reset1    : reset0;

  // Behavioural single-port RAM with bench-side clear/load port.
  always @(posedge clk) begin
    if (ram_clear) begin
      for (int i = 0; i < 2048; i++) ram[i] <= 16'h0000;
    end else if (ram_load) begin
      ram[ram_load_addr] <= ram_load_data;
    end else if (m_write) begin
      ram[m_addr] <= m_din;
    end
    if (m_read) rdata <= ram[m_addr];
  end

  // Cycles since the selected DUT left reset.
  always @(posedge clk) begin
    if (m_reset) cyc <= 0;
    else         cyc <= cyc + 1;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual %0h required %0h", name, actual, expected);
    end
  endtask

  task automatic addWord(input logic [10:0] a, input logic [15:0] d);
    prog_a.push_back(a);
    prog_d.push_back(d);
  endtask

  task automatic expectStore(input logic [10:0] a, input logic [15:0] d);
    store_t s;
    s.addr = a;
    s.data = d;
    store_q.push_back(s);
  endtask

  task automatic expectHalt(input logic [15:0] a, input logic [10:0] p, input logic e, input logic z, input int c);
    halt_t h;
    h.acc = a;
    h.pc = p;
    h.err = e;
    h.dz = z;
    h.cycles = c;
    halt_q.push_back(h);
  endtask

  // Monitor: compare every store strobe and every entry into HALT against the queues.
  initial begin : monitor
    logic   halted_prev;
    store_t s;
    halt_t  h;
    halted_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (m_read && m_write) begin
        errors++;
        $display("[TB] FAIL strobe exclusivity: actual read=1 write=1 required not both");
      end
      if (m_write) begin
        if (store_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected store: actual addr %0h data %0h required none", m_addr, m_din);
        end else begin
          s = store_q.pop_front();
          checkOutput("store address", 32'(m_addr), 32'(s.addr));
          checkOutput("store data", 32'(m_din), 32'(s.data));
        end
      end
      if (m_halted && !halted_prev) begin
        if (halt_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected halt: actual pc %0h required none", m_pc);
        end else begin
          h = halt_q.pop_front();
          checkOutput("halt acc", 32'(m_acc), 32'(h.acc));
          checkOutput("halt pc", 32'(m_pc), 32'(h.pc));
          checkOutput("halt err", 32'(m_err), 32'(h.err));
          checkOutput("halt div_zero", 32'(m_dz), 32'(h.dz));
          checkOutput("halt cycle", 32'(cyc), 32'(h.cycles));
        end
      end
      halted_prev = m_halted;
    end
  end

  // Hold both DUTs in reset, clear RAM, load the queued program, check reset state.
  task automatic loadProgram(input bit alt);
    @(negedge clk);
    reset0 = 1'b1;
    reset1 = 1'b1;
    sel = alt;
    ram_clear = 1'b1;
    @(negedge clk);
    ram_clear = 1'b0;
    for (int i = 0; i < prog_a.size(); i++) begin
      ram_load = 1'b1;
      ram_load_addr = prog_a[i];
      ram_load_data = prog_d[i];
      @(negedge clk);
    end
    ram_load = 1'b0;
    prog_a.delete();
    prog_d.delete();
    @(negedge clk);
    checkOutput("reset pc", 32'(m_pc), alt ? 32'h7FF : 32'h0);
    checkOutput("reset acc", 32'(m_acc), 32'h0);
    checkOutput("reset halted", 32'(m_halted), 32'h0);
    checkOutput("reset err", 32'(m_err), 32'h0);
    checkOutput("reset div_zero", 32'(m_dz), 32'h0);
    checkOutput("reset mem_read", 32'(m_read), 32'h0);
    checkOutput("reset mem_write", 32'(m_write), 32'h0);
    checkOutput("reset mem_address", 32'(m_addr), 32'h0);
    checkOutput("reset mem_data_in", 32'(m_din), 32'h0);
  endtask

  // Release the selected DUT at a falling edge; the fetch strobe must appear at once.
  task automatic releaseReset(input bit alt, input logic [10:0] start_pc);
    if (alt) reset1 = 1'b0;
    else     reset0 = 1'b0;
    #1;
    checkOutput("first fetch read", 32'(m_read), 32'h1);
    checkOutput("first fetch address", 32'(m_addr), 32'(start_pc));
  endtask

  task automatic runToHalt(input int budget);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (m_halted) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput("halt within budget", 32'(seen), 32'h1);
  endtask

  task automatic applyStimulus(input bit alt, input int budget);
    loadProgram(alt);
    @(negedge clk);
    releaseReset(alt, alt ? 11'h7FF : 11'h000);
    runToHalt(budget);
  endtask

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: actual still running required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    // Load, multiply by memory operand, add immediate, store, halt.
    addWord(0, 16'h180A); addWord(1, 16'h580B); addWord(2, 16'h3005);
    addWord(3, 16'h280C); addWord(4, 16'h0000);
    addWord(10, 16'h0009); addWord(11, 16'hFFFC);
    expectStore(12, 16'hFFE1);
    expectHalt(16'hFFE1, 11'd5, 1'b0, 1'b0, 20);
    applyStimulus(1'b0, 100);
    checkOutput("ram[12] after run", 32'(ram[12]), 32'hFFE1);

    // Longer mixed program with three stores and a memory divide.
    addWord(0, 16'h1815); addWord(1, 16'h5816); addWord(2, 16'h3814);
    addWord(3, 16'h4005); addWord(4, 16'h2819); addWord(5, 16'h1817);
    addWord(6, 16'h3818); addWord(7, 16'h3001); addWord(8, 16'h281F);
    addWord(9, 16'h1819); addWord(10, 16'h681F); addWord(11, 16'h2819);
    addWord(12, 16'h0000);
    addWord(20, 16'h0002); addWord(21, 16'h0003); addWord(22, 16'h0005);
    addWord(23, 16'h0008); addWord(24, 16'hFFFB);
    expectStore(25, 16'h000C);
    expectStore(31, 16'h0004);
    expectStore(25, 16'h0003);
    expectHalt(16'h0003, 11'd13, 1'b0, 1'b0, 56);
    applyStimulus(1'b0, 200);
    checkOutput("ram[25] after run", 32'(ram[25]), 32'h0003);
    checkOutput("ram[31] after run", 32'(ram[31]), 32'h0004);

    // Divide by immediate -1, then by a zero memory operand, then keep going.
    addWord(0, 16'h1005); addWord(1, 16'h67FF); addWord(2, 16'h6806);
    addWord(3, 16'h3001); addWord(4, 16'h0000); addWord(6, 16'h0000);
    expectHalt(16'hFFFC, 11'd5, 1'b0, 1'b1, 17);
    applyStimulus(1'b0, 100);

    // Signed truncation toward zero and the 8000 / -1 wrap.
    addWord(0, 16'h17F9); addWord(1, 16'h6002); addWord(2, 16'h281E);
    addWord(3, 16'h1814); addWord(4, 16'h67FF); addWord(5, 16'h281F);
    addWord(6, 16'h0000); addWord(20, 16'h8000);
    expectStore(30, 16'hFFFD);
    expectStore(31, 16'h8000);
    expectHalt(16'h8000, 11'd7, 1'b0, 1'b0, 25);
    applyStimulus(1'b0, 100);

    // Subtract immediate -1 from zero, then an illegal opcode.
    addWord(0, 16'h1000); addWord(1, 16'h47FF); addWord(2, 16'h7000);
    expectHalt(16'h0001, 11'd3, 1'b1, 1'b0, 9);
    applyStimulus(1'b0, 100);

    // STORE with an immediate operand is illegal and must not strobe.
    addWord(0, 16'h3002); addWord(1, 16'h2005); addWord(5, 16'h1234);
    expectHalt(16'h0002, 11'd2, 1'b1, 1'b0, 6);
    applyStimulus(1'b0, 100);
    checkOutput("ram[5] after illegal store", 32'(ram[5]), 32'h1234);

    // Reset raised while in the STORE state aborts the write.
    addWord(0, 16'h2805); addWord(1, 16'h0000); addWord(5, 16'hBEEF);
    expectStore(5, 16'h0000);
    expectHalt(16'h0000, 11'd2, 1'b0, 1'b0, 7);
    loadProgram(1'b0);
    @(negedge clk);
    releaseReset(1'b0, 11'h000);
    repeat (3) @(posedge clk);
    #1 reset0 = 1'b1;
    @(negedge clk);
    checkOutput("aborted store write", 32'(m_write), 32'h0);
    checkOutput("aborted store read", 32'(m_read), 32'h0);
    @(negedge clk);
    checkOutput("abort pc", 32'(m_pc), 32'h0);
    checkOutput("abort ram[5]", 32'(ram[5]), 32'hBEEF);
    releaseReset(1'b0, 11'h000);
    runToHalt(100);

    // Reset PC at the top of memory: PC wraps to 0 after the first fetch.
    addWord(11'h7FF, 16'h3001); addWord(0, 16'h0000);
    expectHalt(16'h0001, 11'd1, 1'b0, 1'b0, 6);
    applyStimulus(1'b1, 100);

    @(negedge clk);
    @(negedge clk);
    checkOutput("store queue drained", 32'(store_q.size()), 32'h0);
    checkOutput("halt queue drained", 32'(halt_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
